// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side (the arithmetic unit) returns results.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_ovf;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_sum, o_carry, o_ovf
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_sum, o_carry, o_ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one registered full-adder cell, operands consumed LSB-first,
// one bit per clock. Subtraction is a + ~b + 1 (inverted b, carry-in preset to 1).
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serial_addsub_if.slave       bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Last bit index and the one before it; for WIDTH = 1 the penultimate index is never reached
    // and the carry into the MSB stays at the initial carry-in.
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntPen  = CntW'(WIDTH - 2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] s_msb;

    // Full-adder cell on the current LSBs; sum bit positioned at the result MSB.
    always_comb begin
        bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        s_msb = '0;
        s_msb[WIDTH-1] = bit_s;
    end

    // Next-state: accept a start in idle, then shift one bit per clock until the last bit.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d   = StRun;
                    a_sh_d    = bus.i_a;
                    b_sh_d    = bus.i_sub ? ~bus.i_b : bus.i_b;
                    carry_d   = bus.i_sub;
                    cin_msb_d = bus.i_sub;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            StRun: begin
                res_d   = (res_q >> 1) | s_msb;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntPen) begin
                    cin_msb_d = bit_c;
                end
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    sum_d   = (res_q >> 1) | s_msb;
                    cout_d  = bit_c;
                    ovf_d   = bit_c ^ cin_msb_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = cout_q;
    assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: one 8-bit and one 1-bit instance.
module tb_serial_addsub;

    typedef struct {
        logic [7:0]  sum;
        logic        c;
        logic        v;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    logic [9:0] held8 = '0;
    logic [2:0] held1 = '0;

    serial_addsub_if #(.WIDTH(8)) b8 ();
    serial_addsub_if #(.WIDTH(1)) b1 ();

    serial_addsub #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(b8));
    serial_addsub #(.WIDTH(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t       r;
        logic [7:0] bb;
        logic [8:0] f;
        bb    = sub ? ~b : b;
        f     = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        r.sum = f[7:0];
        r.c   = f[8];
        r.v   = (a[7] == bb[7]) && (f[7] != a[7]);
        r.at  = 0;
        return r;
    endfunction

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (b8.o_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout8", 32'd1, 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input exp_t e);
        exp_t x;
        wait_idle8();
        x    = e;
        x.at = cyc + 1 + 8;
        b8.i_start = 1'b1;
        b8.i_a     = a;
        b8.i_b     = b;
        b8.i_sub   = sub;
        q8.push_back(x);
        @(negedge clk);
        b8.i_start = 1'b0;
    endtask

    task automatic op1(input logic a, input logic b, input logic sub);
        exp_t x;
        logic bp;
        int   n = 0;
        @(negedge clk);
        while (b1.o_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout1", 32'd1, 32'd0);
        bp    = b ^ sub;
        x.sum = {7'd0, a ^ bp ^ sub};
        x.c   = (a & bp) | (a & sub) | (bp & sub);
        x.v   = x.c ^ sub;
        x.at  = cyc + 1 + 1;
        b1.i_start = 1'b1;
        b1.i_a     = a;
        b1.i_b     = b;
        b1.i_sub   = sub;
        q1.push_back(x);
        @(negedge clk);
        b1.i_start = 1'b0;
    endtask

    // 8-bit monitor: pop on done, check latency and hold of results between completions.
    always @(negedge clk) begin
        if (rst) begin
            held8 = '0;
        end else if (b8.o_done) begin
            check("busy_at_done8", {31'd0, b8.o_busy}, 32'd0);
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sum8", {24'd0, b8.o_sum}, {24'd0, e8.sum});
                check("carry8", {31'd0, b8.o_carry}, {31'd0, e8.c});
                check("ovf8", {31'd0, b8.o_ovf}, {31'd0, e8.v});
                check("latency8", cyc, e8.at);
            end
            held8 = {b8.o_sum, b8.o_carry, b8.o_ovf};
        end else begin
            check("hold8", {22'd0, b8.o_sum, b8.o_carry, b8.o_ovf}, {22'd0, held8});
            if (q8.size() > 0 && cyc > q8[0].at) begin
                check("late_done8", cyc, q8[0].at);
                void'(q8.pop_front());
            end
        end
    end

    // 1-bit monitor.
    always @(negedge clk) begin
        if (rst) begin
            held1 = '0;
        end else if (b1.o_done) begin
            check("busy_at_done1", {31'd0, b1.o_busy}, 32'd0);
            if (q1.size() == 0) begin
                check("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("sum1", {31'd0, b1.o_sum}, {31'd0, e1.sum[0]});
                check("carry1", {31'd0, b1.o_carry}, {31'd0, e1.c});
                check("ovf1", {31'd0, b1.o_ovf}, {31'd0, e1.v});
                check("latency1", cyc, e1.at);
            end
            held1 = {b1.o_sum, b1.o_carry, b1.o_ovf};
        end else begin
            check("hold1", {29'd0, b1.o_sum, b1.o_carry, b1.o_ovf}, {29'd0, held1});
            if (q1.size() > 0 && cyc > q1[0].at) begin
                check("late_done1", cyc, q1[0].at);
                void'(q1.pop_front());
            end
        end
    end

    initial begin
        exp_t        e;
        int          n;
        logic [7:0]  ra, rb;
        logic        rs;

        b8.i_start = 1'b0; b8.i_sub = 1'b0; b8.i_a = '0; b8.i_b = '0;
        b1.i_start = 1'b0; b1.i_sub = 1'b0; b1.i_a = '0; b1.i_b = '0;

        repeat (3) @(negedge clk);
        check("rst_out8", {19'd0, b8.o_busy, b8.o_done, b8.o_sum, b8.o_carry, b8.o_ovf}, 32'd0);
        check("rst_out1", {27'd0, b1.o_busy, b1.o_done, b1.o_sum, b1.o_carry, b1.o_ovf}, 32'd0);
        rst = 1'b0;

        // Exhaustive 1-bit.
        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0]);
        end

        // Directed 8-bit vectors with hand-derived results.
        e = '{8'h96, 1'b0, 1'b1, 0}; op8(8'h5A, 8'h3C, 1'b0, e);
        e = '{8'h00, 1'b1, 1'b0, 0}; op8(8'hFF, 8'h01, 1'b0, e);
        e = '{8'hF0, 1'b0, 1'b0, 0}; op8(8'h10, 8'h20, 1'b1, e);
        e = '{8'h7F, 1'b1, 1'b1, 0}; op8(8'h80, 8'h01, 1'b1, e);
        e = '{8'h00, 1'b1, 1'b0, 0}; op8(8'h33, 8'h33, 1'b1, e);

        // Busy protection: extra starts mid-operation must be ignored.
        e = '{8'h03, 1'b0, 1'b0, 0}; op8(8'h01, 8'h02, 1'b0, e);
        b8.i_a = 8'hFF; b8.i_b = 8'hFF; b8.i_sub = 1'b0;
        @(negedge clk); b8.i_start = 1'b1; @(negedge clk); b8.i_start = 1'b0;
        repeat (3) @(negedge clk);
        b8.i_start = 1'b1; @(negedge clk); b8.i_start = 1'b0;

        // Back-to-back: issue the next start in the done cycle.
        e = '{8'h42, 1'b0, 1'b0, 0}; op8(8'h20, 8'h22, 1'b0, e);
        n = 0;
        while (!b8.o_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", {31'd0, b8.o_done}, 32'd1);
        check("b2b_busy_in_done", {31'd0, b8.o_busy}, 32'd0);
        e    = '{8'h11, 1'b0, 1'b0, 0};
        e.at = cyc + 1 + 8;
        b8.i_start = 1'b1; b8.i_a = 8'h10; b8.i_b = 8'h01; b8.i_sub = 1'b0;
        q8.push_back(e);
        @(negedge clk);
        b8.i_start = 1'b0;
        check("b2b_busy_next", {31'd0, b8.o_busy}, 32'd1);
        check("b2b_sum_held", {24'd0, b8.o_sum}, 32'h42);

        // Reset mid-operation: outputs clear at once, no done for the aborted op.
        wait_idle8();
        b8.i_start = 1'b1; b8.i_a = 8'h44; b8.i_b = 8'h11; b8.i_sub = 1'b0;
        @(negedge clk);
        b8.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out8", {19'd0, b8.o_busy, b8.o_done, b8.o_sum, b8.o_carry, b8.o_ovf}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        e = '{8'h05, 1'b0, 1'b0, 0}; op8(8'h02, 8'h03, 1'b0, e);

        // A few model-checked random operations.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            op8(ra, rb, rs, model8(ra, rb, rs));
        end

        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Bit-serial adder/subtractor built around a single registered full-adder cell (a + b + carry-in per clock).
- Accepts two WIDTH-bit operands and an operation select on a start pulse.
- Processes operands LSB-first, one bit per clock.
- Returns the WIDTH-bit result with carry/no-borrow and signed overflow flags.
- Used as the low-area arithmetic unit wherever a parallel adder is too costly and WIDTH cycles of latency are acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start  input  1  start request, sampled on rising edge when idle
i_sub  input  1  0 = add (a + b), 1 = subtract (a - b); sampled with i_start
i_a  input  WIDTH  operand a; sampled with i_start
i_b  input  WIDTH  operand b; sampled with i_start
o_busy  output  1  high while an operation is in progress
o_done  output  1  one-cycle pulse, result valid
o_sum  output  WIDTH  result; held stable from o_done until the next accepted start
o_carry  output  1  add: carry-out; sub: no-borrow (1 when a >= b unsigned)
o_ovf  output  1  two's-complement signed overflow

Behaviour:
- Clocking and reset: one clock (i_clk). Reset i_rst is asynchronous and active-high.
- Values on reset: state = IDLE; o_busy, o_done, o_carry, o_ovf = 0; o_sum = 0; bit counter = 0; internal shift and carry registers = 0.
- States:
  - IDLE: accepts a start.
  - RUN: one bit processed per clock.
- IDLE -> RUN: on a rising edge with i_start = 1.
  - a_sh <= i_a.
  - b_sh <= i_sub ? ~i_b : i_b.
  - carry <= i_sub.
  - cnt <= 0; o_busy <= 1; o_done <= 0.
- Each RUN edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = majority(a_sh[0], b_sh[0], carry).
  - Shift s into the MSB of the result register; shift a_sh and b_sh right by 1.
  - carry <= c; cnt <= cnt + 1.
  - When cnt = WIDTH-2, also record carry-into-MSB = c, used for o_ovf.
- RUN -> IDLE: on the edge where cnt = WIDTH-1, i.e. the final bit.
  - o_sum <= completed result.
  - o_carry <= c.
  - o_ovf <= c XOR carry-into-MSB.
  - o_done <= 1 for exactly one cycle; o_busy <= 0.
- Latency: start accepted at edge k; o_done high and result valid in the cycle after edge k+WIDTH. Exactly WIDTH clocks in RUN.
- WIDTH = 1:
  - carry-into-MSB = initial carry (i_sub).
  - Done occurs one edge after start.
- Start handling:
  - i_start while o_busy = 1 is ignored; the operation and operands in flight are unaffected.
  - i_start in the same cycle o_done = 1 is accepted (state is IDLE), giving back-to-back operations.
  - The next op's o_busy rises on the following edge; o_sum keeps the old result until the new op completes.
- o_sum, o_carry and o_ovf change only at completion or reset; never mid-operation.
- o_done and o_busy are never both 1.
- Reset mid-operation: immediate return to values on reset. The partial result is discarded, with no o_done pulse.
- Arithmetic is modulo 2^WIDTH. The subtract result equals a + ~b + 1.

Test Plan:
- Exhaustive 1-bit check (WIDTH=1): all 8 combinations of (a, b, sub) -> o_sum = a ^ b' ^ sub and o_carry = majority(a, b', sub), where b' = b ^ sub; o_done exactly 1 edge after start.
- WIDTH=8 add: 0x5A+0x3C -> o_sum=0x96, o_carry=0, o_ovf=1. 0xFF+0x01 -> o_sum=0x00, o_carry=1, o_ovf=0. o_done exactly 8 edges after start.
- WIDTH=8 subtract: 0x10-0x20 -> o_sum=0xF0, o_carry=0, o_ovf=0. 0x80-0x01 -> o_sum=0x7F, o_carry=1, o_ovf=1. 0x33-0x33 -> 0x00, o_carry=1.
- Busy protection: start 0x01+0x02, then pulse i_start with 0xFF+0xFF at cycles 3 and 7 -> result 0x03, single o_done, second request never executed.
- Back-to-back: assert i_start with 0x10+0x01 in the o_done cycle of the previous op -> o_sum holds the old value 8 cycles, then 0x11; o_busy low only during o_done cycles.
- Reset mid-op: assert i_rst asynchronously at cycle 4 of RUN -> all outputs 0 immediately, no o_done. A fresh 0x02+0x03 after release -> 0x05.
